dlfloat_operand_loader: RTL and testbench



---
 rtl/dlfloat_operand_loader.sv | 164 ++++++++++++++++
 tb/tb_dlfloat_operand_loader.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dlfloat_operand_loader.sv
// rtl/dlfloat_operand_loader.sv - byte-serial operand pair assembler and FIFO feeder for the dlfloat16 MAC
module dlfloat_operand_loader #(
    parameter int DEPTH = 4,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] vec_len,
    input  logic [7:0]       in_byte,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [15:0]      op_a,
    output logic [15:0]      op_b,
    output logic             op_valid,
    input  logic             op_ready,
    output logic             acc_clr,
    output logic             last,
    output logic             busy,
    output logic             done
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    // FIFO entry layout: {A[15:0], B[15:0], first, last}
    localparam int ENT_W = 34;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               done_nxt;
    logic               done_q;

    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   pairs_in;
    logic [1:0]         byte_idx;
    logic [7:0]         a_lo;
    logic [7:0]         a_hi;
    logic [7:0]         b_lo;

    logic [ENT_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [ENT_W-1:0]   head;

    logic               start_vec;
    logic               byte_fire;
    logic               push;
    logic               pop;
    logic               is_first;
    logic               is_last;

    // Intake is gated on a free slot at every byte position, so a pair in
    // assembly can always be pushed once its fourth byte arrives.
    assign in_ready  = (state == LOAD) && (count < CNT_W'(DEPTH));
    assign byte_fire = in_valid && in_ready;
    assign push      = byte_fire && (byte_idx == 2'd3);
    assign start_vec = (state == IDLE) && start && (vec_len != '0);

    assign is_first  = (pairs_in == '0);
    assign is_last   = (pairs_in == (len_q - 1'b1));

    assign head      = mem[rd_ptr];
    assign op_valid  = (count != '0);
    assign pop       = op_valid && op_ready;
    assign op_a      = head[33:18];
    assign op_b      = head[17:2];
    assign acc_clr   = head[1];
    assign last      = head[0];

    assign busy      = (state != IDLE);
    assign done      = done_q;

    // State register and registered done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= done_nxt;
        end
    end

    // Next-state logic: vector start, last pair pushed, last pair popped.
    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start && (vec_len == '0)) begin
                    done_nxt = 1'b1;
                end else if (start) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (push && is_last) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && head[0]) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Byte assembly, pair counting and FIFO storage; reset wipes partial bytes and queued pairs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q    <= '0;
            pairs_in <= '0;
            byte_idx <= 2'd0;
            a_lo     <= 8'h00;
            a_hi     <= 8'h00;
            b_lo     <= 8'h00;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (start_vec) begin
                len_q    <= vec_len;
                pairs_in <= '0;
                byte_idx <= 2'd0;
            end
            if (byte_fire) begin
                byte_idx <= byte_idx + 2'd1;
                case (byte_idx)
                    2'd0:    a_lo <= in_byte;
                    2'd1:    a_hi <= in_byte;
                    2'd2:    b_lo <= in_byte;
                    default: b_lo <= b_lo;
                endcase
            end
            if (push) begin
                mem[wr_ptr] <= {a_hi, a_lo, in_byte, b_lo, is_first, is_last};
                wr_ptr      <= wr_ptr + 1'b1;
                pairs_in    <= pairs_in + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_dlfloat_operand_loader.sv
// tb/tb_dlfloat_operand_loader.sv - scoreboard bench for dlfloat_operand_loader
module tb_dlfloat_operand_loader;

    localparam int DEPTH = 4;
    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] vec_len;
    logic [7:0]       in_byte;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      op_a;
    logic [15:0]      op_b;
    logic             op_valid;
    logic             op_ready;
    logic             acc_clr;
    logic             last;
    logic             busy;
    logic             done;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  tx_q[$];
    logic [33:0] exp_q[$];

    bit          s_took, s_pop, s_inr, s_ov, s_busy, s_done;
    logic [33:0] s_head;

    dlfloat_operand_loader #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .vec_len  (vec_len),
        .in_byte  (in_byte),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op_a     (op_a),
        .op_b     (op_b),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .acc_clr  (acc_clr),
        .last     (last),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic queue_pair(input logic [15:0] a, input logic [15:0] b, input bit f, input bit l);
        tx_q.push_back(a[7:0]);
        tx_q.push_back(a[15:8]);
        tx_q.push_back(b[7:0]);
        tx_q.push_back(b[15:8]);
        exp_q.push_back({a, b, f, l});
    endtask

    // One clock: drive at the falling edge, snapshot outputs, then let the rising edge happen.
    task automatic cycle(input bit st, input logic [LEN_W-1:0] len, input bit rdy);
        @(negedge clk);
        start    = st;
        vec_len  = len;
        in_valid = (tx_q.size() > 0);
        in_byte  = in_valid ? tx_q[0] : 8'h00;
        op_ready = rdy;
        #1;
        s_took = in_valid && in_ready;
        s_pop  = op_valid && op_ready;
        s_inr  = in_ready;
        s_ov   = op_valid;
        s_busy = busy;
        s_done = done;
        s_head = {op_a, op_b, acc_clr, last};
        @(posedge clk);
        if (s_took) void'(tx_q.pop_front());
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; vec_len = '0; in_byte = 8'h00; in_valid = 1'b0; op_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({in_ready, op_valid, acc_clr, last, busy, done} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=000000", {in_ready, op_valid, acc_clr, last, busy, done});
        end
        checks++;
        if ({op_a, op_b} !== 32'h0) begin
            failures++;
            $display("FAIL reset_operands got=%h exp=00000000", {op_a, op_b});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_pair();
        logic [33:0] e;
        cycle(1'b1, 8'd1, 1'b0);
        queue_pair(16'h3E00, 16'h4000, 1'b1, 1'b1);
        for (int c = 0; c < 10 && tx_q.size() > 0; c++) cycle(1'b0, 8'd0, 1'b0);
        checks++;
        if (tx_q.size() != 0) begin
            failures++;
            $display("FAIL single_intake left=%0d exp=0", tx_q.size());
        end
        checks++;
        if (s_ov !== 1'b0) begin
            failures++;
            $display("FAIL single_early_valid got=%b exp=0", s_ov);
        end
        cycle(1'b0, 8'd0, 1'b0);
        checks++;
        if ({s_ov, s_inr, s_busy} !== 3'b101) begin
            failures++;
            $display("FAIL single_latency valid_inready_busy got=%b exp=101", {s_ov, s_inr, s_busy});
        end
        cycle(1'b0, 8'd0, 1'b1);
        e = 'x;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        checks++;
        if (s_pop !== 1'b1 || s_head !== e) begin
            failures++;
            $display("FAIL single_pair pop=%b got=%h exp=%h", s_pop, s_head, e);
        end
        cycle(1'b0, 8'd0, 1'b0);
        checks++;
        if ({s_done, s_busy, s_ov} !== 3'b100) begin
            failures++;
            $display("FAIL single_done done_busy_valid got=%b exp=100", {s_done, s_busy, s_ov});
        end
        cycle(1'b0, 8'd0, 1'b0);
        checks++;
        if (s_done !== 1'b0) begin
            failures++;
            $display("FAIL single_done_width got=%b exp=0", s_done);
        end
    endtask

    task automatic test_backpressure();
        logic [33:0] e;
        int pops = 0;
        int dones = 0;
        cycle(1'b1, 8'd3, 1'b0);
        queue_pair(16'h3E00, 16'h4000, 1'b1, 1'b0);
        queue_pair(16'h4000, 16'h3E00, 1'b0, 1'b0);
        queue_pair(16'hBE00, 16'h4000, 1'b0, 1'b1);
        for (int c = 0; c < 100 && dones == 0; c++) begin
            cycle(1'b0, 8'd0, tx_q.size() == 0);
            if (s_pop) begin
                pops++;
                e = 'x;
                if (exp_q.size() > 0) e = exp_q.pop_front();
                checks++;
                if (s_head !== e) begin
                    failures++;
                    $display("FAIL bp_pair%0d got=%h exp=%h", pops, s_head, e);
                end
            end
            if (s_done) dones++;
        end
        checks++;
        if (pops != 3 || dones != 1) begin
            failures++;
            $display("FAIL bp_counts pops=%0d dones=%0d exp=3,1", pops, dones);
        end
        cycle(1'b0, 8'd0, 1'b0);
        checks++;
        if (s_done !== 1'b0 || s_busy !== 1'b0) begin
            failures++;
            $display("FAIL bp_idle done=%b busy=%b exp=0,0", s_done, s_busy);
        end
    endtask

    task automatic test_fifo_full();
        logic [33:0] e;
        int pops = 0;
        int dones = 0;
        int took = 0;
        cycle(1'b1, 8'd6, 1'b0);
        for (int p = 0; p < 6; p++)
            queue_pair(16'h1000 + 16'(p), 16'h2000 + 16'(p), p == 0, p == 5);
        for (int c = 0; c < 40 && tx_q.size() > 8; c++) cycle(1'b0, 8'd0, 1'b0);
        cycle(1'b0, 8'd0, 1'b0);
        checks++;
        if (s_inr !== 1'b0 || s_took !== 1'b0 || tx_q.size() != 8) begin
            failures++;
            $display("FAIL full_stall in_ready=%b left=%0d exp=0,8", s_inr, tx_q.size());
        end
        cycle(1'b0, 8'd0, 1'b1);
        e = 'x;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        checks++;
        if (s_pop !== 1'b1 || s_head !== e) begin
            failures++;
            $display("FAIL full_one_pop pop=%b got=%h exp=%h", s_pop, s_head, e);
        end
        if (s_pop) pops++;
        for (int c = 0; c < 12; c++) begin
            cycle(1'b0, 8'd0, 1'b0);
            if (s_took) took++;
        end
        checks++;
        if (took != 4 || s_inr !== 1'b0) begin
            failures++;
            $display("FAIL full_refill bytes=%0d in_ready=%b exp=4,0", took, s_inr);
        end
        for (int c = 0; c < 100 && dones == 0; c++) begin
            cycle(1'b0, 8'd0, 1'b1);
            if (s_pop) begin
                pops++;
                e = 'x;
                if (exp_q.size() > 0) e = exp_q.pop_front();
                checks++;
                if (s_head !== e) begin
                    failures++;
                    $display("FAIL full_pair%0d got=%h exp=%h", pops, s_head, e);
                end
            end
            if (s_done) dones++;
        end
        checks++;
        if (pops != 6 || dones != 1) begin
            failures++;
            $display("FAIL full_counts pops=%0d dones=%0d exp=6,1", pops, dones);
        end
    endtask

    task automatic test_zero_length();
        cycle(1'b1, 8'd0, 1'b0);
        cycle(1'b0, 8'd0, 1'b0);
        checks++;
        if ({s_done, s_busy, s_ov, s_inr} !== 4'b1000) begin
            failures++;
            $display("FAIL zero_len done_busy_valid_inready got=%b exp=1000", {s_done, s_busy, s_ov, s_inr});
        end
        cycle(1'b0, 8'd0, 1'b0);
        checks++;
        if ({s_done, s_busy} !== 2'b00) begin
            failures++;
            $display("FAIL zero_len_after done_busy got=%b exp=00", {s_done, s_busy});
        end
    endtask

    task automatic test_reset_mid();
        logic [33:0] e;
        int pops = 0;
        int dones = 0;
        cycle(1'b1, 8'd2, 1'b0);
        queue_pair(16'h1111, 16'h2222, 1'b1, 1'b0);
        queue_pair(16'h3333, 16'h4444, 1'b0, 1'b1);
        for (int c = 0; c < 20 && tx_q.size() > 2; c++) cycle(1'b0, 8'd0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({op_valid, busy, in_ready} !== 3'b000) begin
            failures++;
            $display("FAIL reset_mid valid_busy_inready got=%b exp=000", {op_valid, busy, in_ready});
        end
        in_valid = 1'b0;
        tx_q.delete();
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b1, 8'd1, 1'b0);
        queue_pair(16'h5555, 16'h6666, 1'b1, 1'b1);
        for (int c = 0; c < 40 && dones == 0; c++) begin
            cycle(1'b0, 8'd0, 1'b1);
            if (s_pop) begin
                pops++;
                e = 'x;
                if (exp_q.size() > 0) e = exp_q.pop_front();
                checks++;
                if (s_head !== e) begin
                    failures++;
                    $display("FAIL reset_mid_pair got=%h exp=%h", s_head, e);
                end
            end
            if (s_done) dones++;
        end
        checks++;
        if (pops != 1 || dones != 1) begin
            failures++;
            $display("FAIL reset_mid_counts pops=%0d dones=%0d exp=1,1", pops, dones);
        end
    endtask

    task automatic test_start_while_busy();
        logic [33:0] e;
        int pops = 0;
        int dones = 0;
        cycle(1'b1, 8'd2, 1'b0);
        queue_pair(16'h0102, 16'h0304, 1'b1, 1'b0);
        queue_pair(16'h0506, 16'h0708, 1'b0, 1'b1);
        for (int c = 0; c < 80; c++) begin
            cycle(c == 3, 8'd9, 1'b1);
            if (s_pop) begin
                pops++;
                e = 'x;
                if (exp_q.size() > 0) e = exp_q.pop_front();
                checks++;
                if (s_head !== e) begin
                    failures++;
                    $display("FAIL busy_start_pair%0d got=%h exp=%h", pops, s_head, e);
                end
            end
            if (s_done) dones++;
        end
        checks++;
        if (pops != 2 || dones != 1 || s_busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_start pops=%0d dones=%0d busy=%b exp=2,1,0", pops, dones, s_busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [33:0] e;
        int pops = 0;
        int dones = 0;
        cycle(1'b1, 8'd3, 1'b0);
        queue_pair(16'h0000, 16'h0000, 1'b1, 1'b0);
        queue_pair(16'h8000, 16'h0000, 1'b0, 1'b0);
        queue_pair(16'hFFFF, 16'h0001, 1'b0, 1'b1);
        for (int v = 0; v < 2; v++) begin
            for (int c = 0; c < 200 && dones == v; c++) begin
                cycle(1'b0, 8'd0, 1'($urandom_range(0, 1)));
                if (s_pop) begin
                    pops++;
                    e = 'x;
                    if (exp_q.size() > 0) e = exp_q.pop_front();
                    checks++;
                    if (s_head !== e) begin
                        failures++;
                        $display("FAIL b2b_pair%0d got=%h exp=%h", pops, s_head, e);
                    end
                end
                if (s_done) dones++;
            end
            if (v == 0) begin
                cycle(1'b1, 8'd1, 1'b0);
                queue_pair(16'h0000, 16'h3C00, 1'b1, 1'b1);
            end
        end
        checks++;
        if (pops != 4 || dones != 2) begin
            failures++;
            $display("FAIL b2b_counts pops=%0d dones=%0d exp=4,2", pops, dones);
        end
    endtask

    initial begin
        test_reset();
        test_single_pair();
        test_backpressure();
        test_fifo_full();
        test_zero_length();
        test_reset_mid();
        test_start_while_busy();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
